rvm_payout_ctrl: RTL and testbench
==================================

// Module: rvm_payout_ctrl
// PURPOSE
//  Consumer side of the RVM bottle count: redeems accumulated bottles as coins.
//  On a redeem press it snapshots bot_count, pulses clr_count back to the counter,
//  then drives the coin dispenser one coin at a time over a 4-phase req/ack handshake.
//  Sits between bottle_counter (input) and the coin dispenser driver (output).
// PARAMETERS
//  CNT_W            4     width of bot_count from the bottle counter
//  COINS_PER_BOTTLE 1     coins paid per bottle (1..15)
//  TIMEOUT_CYC      1000  max cycles waiting on any ack edge before FAULT
//  GAP_CYC          10    idle cycles between consecutive coins (>=1)
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-low reset
//  redeem      in   1      user redeem button (synchronous level, rising edge acts)
//  bot_count   in   CNT_W  current bottle count
//  coin_ack    in   1      dispenser acknowledge (4-phase)
//  coin_req    out  1      dispense-one-coin request
//  clr_count   out  1      1-cycle pulse: clear the bottle counter
//  busy        out  1      high in every state except IDLE
//  done        out  1      1-cycle pulse: payout complete
//  fault       out  1      sticky: dispenser timeout
//  coins_left  out  8      coins still owed
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all outputs 0; timers 0; redeem edge reg 0.
//  - Edge detect: rise = redeem & ~redeem_q; redeem_q registered every cycle.
//  - States: IDLE, REQ, ACKLO, GAP, DONE, FAULT.
//  - IDLE: rise & bot_count!=0 -> coins_left <= min(bot_count*COINS_PER_BOTTLE,255),
//    clr_count=1 same cycle as the load (one cycle only), -> REQ next cycle.
//    rise & bot_count==0 -> no load, no clr_count, stay IDLE.
//  - REQ: coin_req=1 (registered). coin_ack=1 -> ACKLO, coin_req drops next cycle.
//    timer==TIMEOUT_CYC-1 with no ack -> FAULT.
//  - ACKLO: coin_req=0; coin_ack=0 -> coins_left-1; if result 0 -> DONE else GAP.
//    timeout as in REQ -> FAULT. Timer cleared on every state entry.
//  - GAP: count GAP_CYC cycles -> REQ.
//  - DONE: done=1 for one cycle -> IDLE.
//  - FAULT: fault=1, coin_req=0, coins_left frozen; exit only via reset.
//  - redeem rises while busy: ignored (no queueing). bot_count changes after the
//    load cycle are ignored (counter refills independently; next redeem pays them).
//  - coin_ack high in IDLE/GAP/DONE: ignored; ack already high on REQ entry is
//    accepted immediately (1-cycle REQ).
//  - Latency redeem rise -> first coin_req: 2 cycles (edge reg + load).
//  - Reset mid-payout: coins owed are discarded; clr_count already issued.
// STRUCTURE
//  - Package rvm_pkg: state enum/localparams (IDLE..FAULT), COIN_W=8, defaults above.
//  - One sub-module: rvm_cycle_timer (load/clear, terminal-count flag), used for both
//    TIMEOUT_CYC and GAP_CYC by reloading per state.
//  - Multiply is constant; implement as saturating shift/add, no DSP.
// TESTING
//  1 bot_count=3, redeem pulse, dispenser acks after 2 cyc, releases after 2 ->
//    clr_count 1 pulse, exactly 3 coin_req pulses, coins_left 3->2->1->0, done 1 pulse.
//  2 bot_count=0, redeem pulse -> no clr_count, no coin_req, busy stays 0.
//  3 COINS_PER_BOTTLE=2, bot_count=10 -> coins_left loads 20, 20 req/ack cycles, done.
//  4 bot_count=2, coin_ack never rises -> fault=1 after TIMEOUT_CYC cycles in REQ,
//    coin_req=0, coins_left holds 2; second redeem ignored until reset.
//  5 redeem pulsed again mid-payout and held high 50 cycles -> single payout only,
//    bot_count changes to 5 during payout do not alter coins_left.
//  6 reset asserted while coin_req=1 -> all outputs 0 asynchronously; after release,
//    fresh redeem with bot_count=1 pays exactly 1 coin.

Source files
------------

// File: rtl/rvm_pkg.sv
// Shared types and constants for the RVM payout controller.
// Includes the saturating constant multiply that turns bottles into coins.
package rvm_pkg;

  localparam int COIN_W               = 8;
  localparam int DEF_CNT_W            = 4;
  localparam int DEF_COINS_PER_BOTTLE = 1;
  localparam int DEF_TIMEOUT_CYC      = 1000;
  localparam int DEF_GAP_CYC          = 10;

  localparam logic [COIN_W-1:0] COIN_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACKLO = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // k is a constant at every call site, so the loop folds into a few shifted adds.
  function automatic logic [COIN_W-1:0] sat_mul(input logic [15:0] n,
                                                input logic [3:0]  k);
    logic [19:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc + (20'(n) << i);
    end
    return (acc > 20'(COIN_MAX)) ? COIN_MAX : acc[COIN_W-1:0];
  endfunction

endpackage

// File: rtl/rvm_payout_ctrl_if.sv
// Bundle between the bottle counter, the payout controller and the coin dispenser.
// coin_req/coin_ack is a 4-phase handshake: req rises, ack rises, req falls, ack falls.
interface rvm_payout_ctrl_if #(
  parameter int CNT_W = rvm_pkg::DEF_CNT_W
);
  import rvm_pkg::*;

  logic              redeem;
  logic [CNT_W-1:0]  bot_count;
  logic              coin_ack;
  logic              coin_req;
  logic              clr_count;
  logic              busy;
  logic              done;
  logic              fault;
  logic [COIN_W-1:0] coins_left;

  modport master (
    output redeem, bot_count, coin_ack,
    input  coin_req, clr_count, busy, done, fault, coins_left
  );

  modport slave (
    input  redeem, bot_count, coin_ack,
    output coin_req, clr_count, busy, done, fault, coins_left
  );

endinterface

// File: rtl/rvm_cycle_timer.sv
// Down-counting cycle timer: load a count, tc_o flags when it has run out.
// Shared by the ack timeout and the inter-coin gap, reloaded on each state entry.
module rvm_cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/rvm_payout_ctrl.sv
// Redeems the accumulated bottle count as coins: snapshot, clear the counter,
// then pay one coin per 4-phase handshake with a gap between coins.
module rvm_payout_ctrl
  import rvm_pkg::*;
#(
  parameter int CNT_W            = DEF_CNT_W,
  parameter int COINS_PER_BOTTLE = DEF_COINS_PER_BOTTLE,
  parameter int TIMEOUT_CYC      = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC          = DEF_GAP_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  rvm_payout_ctrl_if.slave bus,
  output state_t           state_o
);

  localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t            state_q;
  logic              redeem_q;
  logic              coin_req_q;
  logic              clr_count_q;
  logic              busy_q;
  logic              done_q;
  logic              fault_q;
  logic [COIN_W-1:0] coins_q;
  logic [COIN_W-1:0] load_coins;

  logic              rise;
  logic              start;
  logic              req_ack;
  logic              req_to;
  logic              lo_rel;
  logic              lo_to;
  logic              gap_end;
  logic              tmr_load;
  logic              tmr_tc;
  logic [TMR_W-1:0]  tmr_val;

  assign rise       = bus.redeem & ~redeem_q;
  assign load_coins = sat_mul(16'(bus.bot_count), 4'(COINS_PER_BOTTLE));

  // Transition events; every one that enters a timed state reloads the timer.
  always_comb begin
    start    = (state_q == ST_IDLE)  && rise && (bus.bot_count != '0);
    req_ack  = (state_q == ST_REQ)   && bus.coin_ack;
    req_to   = (state_q == ST_REQ)   && !bus.coin_ack && tmr_tc;
    lo_rel   = (state_q == ST_ACKLO) && !bus.coin_ack;
    lo_to    = (state_q == ST_ACKLO) && bus.coin_ack && tmr_tc;
    gap_end  = (state_q == ST_GAP)   && tmr_tc;
    tmr_load = start || req_ack || lo_rel || gap_end;
    tmr_val  = lo_rel ? TMR_W'(GAP_CYC - 1) : TMR_W'(TIMEOUT_CYC - 1);
  end

  rvm_cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      redeem_q    <= 1'b0;
      coin_req_q  <= 1'b0;
      clr_count_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      coins_q     <= '0;
    end else begin
      redeem_q    <= bus.redeem;
      clr_count_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            coins_q     <= load_coins;
            clr_count_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        // req stays up through the first ACKLO cycle, so a pre-raised ack still sees a pulse.
        ST_REQ: begin
          coin_req_q <= 1'b1;
          if (req_ack) begin
            state_q <= ST_ACKLO;
          end else if (req_to) begin
            coin_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= ST_FAULT;
          end
        end
        ST_ACKLO: begin
          coin_req_q <= 1'b0;
          if (lo_rel) begin
            coins_q <= coins_q - 1'b1;
            if (coins_q == COIN_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_GAP;
            end
          end else if (lo_to) begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
          end
        end
        ST_GAP: begin
          if (gap_end) state_q <= ST_REQ;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_FAULT: begin
          coin_req_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.coin_req   = coin_req_q;
  assign bus.clr_count  = clr_count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.coins_left = coins_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_rvm_payout_ctrl.sv
// Randomized bench for rvm_payout_ctrl against a coins = min(bottles*rate, 255) model
// with a behavioural 4-phase dispenser and a coins_left scoreboard.
module tb_rvm_payout_ctrl;
  import rvm_pkg::*;

  localparam int CNT_W = 8;
  localparam int CPB   = 2;
  localparam int TMO   = 60;
  localparam int GAP   = 3;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [COIN_W-1:0] exp_q[$];

  // monitor state
  logic              req_prev   = 1'b0;
  logic [COIN_W-1:0] coins_prev = '0;
  int                req_rises  = 0;
  int                clr_cycles = 0;
  int                done_cycles = 0;
  bit                busy_seen  = 1'b0;

  // dispenser state
  bit disp_en  = 1'b1;
  int disp_cnt = 0;
  int dly_ack  = 1;
  int dly_rel  = 1;

  rvm_payout_ctrl_if #(.CNT_W(CNT_W)) dut_if ();

  rvm_payout_ctrl #(
    .CNT_W            (CNT_W),
    .COINS_PER_BOTTLE (CPB),
    .TIMEOUT_CYC      (TMO),
    .GAP_CYC          (GAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (dut_if),
    .state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_coins(input int bottles);
    int p;
    p = bottles * CPB;
    return (p > 255) ? 255 : p;
  endfunction

  task automatic mon_step();
    if (dut_if.coin_req && !req_prev) begin
      req_rises++;
      check("req_rise_ack_low", 32'(dut_if.coin_ack), 0);
    end
    req_prev = dut_if.coin_req;
    if (dut_if.clr_count) clr_cycles++;
    if (dut_if.done) done_cycles++;
    if (dut_if.busy) busy_seen = 1'b1;
    if (dut_if.coins_left != coins_prev) begin
      if (exp_q.size() == 0) check("coins_left_unexpected", 32'(dut_if.coins_left), 32'(coins_prev));
      else                   check("coins_left_seq", 32'(dut_if.coins_left), 32'(exp_q.pop_front()));
      coins_prev = dut_if.coins_left;
    end
  endtask

  task automatic disp_step();
    if (disp_en) begin
      if (dut_if.coin_req && !dut_if.coin_ack) begin
        if (disp_cnt >= dly_ack) begin
          dut_if.coin_ack = 1'b1;
          disp_cnt = 0;
          dly_rel = $urandom_range(0, 3);
        end else disp_cnt++;
      end else if (!dut_if.coin_req && dut_if.coin_ack) begin
        if (disp_cnt >= dly_rel) begin
          dut_if.coin_ack = 1'b0;
          disp_cnt = 0;
          dly_ack = $urandom_range(0, 3);
        end else disp_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_step();
    disp_step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coin_req"}, 32'(dut_if.coin_req), 0);
    check({tag, "_clr_count"}, 32'(dut_if.clr_count), 0);
    check({tag, "_busy"}, 32'(dut_if.busy), 0);
    check({tag, "_done"}, 32'(dut_if.done), 0);
    check({tag, "_fault"}, 32'(dut_if.fault), 0);
    check({tag, "_coins_left"}, 32'(dut_if.coins_left), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Asserts reset mid-cycle, away from any clock edge.
  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    dut_if.coin_ack = 1'b0;
    disp_cnt = 0;
    exp_q.delete();
    req_prev   = dut_if.coin_req;
    coins_prev = dut_if.coins_left;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_payout(input int bottles, input bit mid_press);
    int exp_n, r0, c0, d0, budget, k;
    exp_n = model_coins(bottles);
    r0 = req_rises; c0 = clr_cycles; d0 = done_cycles;
    busy_seen = 1'b0;
    dut_if.bot_count = CNT_W'(bottles);
    if (exp_n > 0) begin
      for (int i = exp_n; i >= 0; i--) exp_q.push_back(COIN_W'(i));
    end
    dut_if.redeem = 1'b1;
    tick();
    if (exp_n == 0) begin
      for (int i = 0; i < 6; i++) begin
        if (i == 1) dut_if.redeem = 1'b0;
        tick();
      end
      check("zero_no_clr", 32'(clr_cycles - c0), 0);
      check("zero_no_req", 32'(req_rises - r0), 0);
      check("zero_busy_low", 32'(busy_seen), 0);
      return;
    end
    check("load_clr", 32'(dut_if.clr_count), 1);
    check("load_busy", 32'(dut_if.busy), 1);
    tick();
    check("first_req_latency", 32'(dut_if.coin_req), 1);
    dut_if.redeem = 1'b0;
    budget = exp_n * 20 + 50;
    k = 0;
    while (done_cycles == d0 && budget > 0) begin
      if (mid_press) begin
        if (k == 5)  dut_if.redeem = 1'b1;
        if (k == 6)  dut_if.bot_count = CNT_W'(5);
        if (k == 55) dut_if.redeem = 1'b0;
      end
      tick();
      k++;
      budget--;
    end
    check("payout_timeout", 32'(budget == 0), 0);
    dut_if.redeem = 1'b0;
    tick();
    tick();
    check("req_count", 32'(req_rises - r0), 32'(exp_n));
    check("clr_pulse", 32'(clr_cycles - c0), 1);
    check("done_pulse", 32'(done_cycles - d0), 1);
    check("final_coins", 32'(dut_if.coins_left), 0);
    check("idle_busy", 32'(dut_if.busy), 0);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic run_fault();
    int cnt, r0, c0;
    disp_en = 1'b0;
    dut_if.coin_ack = 1'b0;
    r0 = req_rises; c0 = clr_cycles;
    dut_if.bot_count = CNT_W'(2);
    exp_q.push_back(COIN_W'(model_coins(2)));
    dut_if.redeem = 1'b1;
    tick();
    dut_if.redeem = 1'b0;
    check("fault_load_clr", 32'(dut_if.clr_count), 1);
    cnt = 0;
    while (!dut_if.fault && cnt < TMO + 20) begin
      tick();
      cnt++;
    end
    check("fault_latency", 32'(cnt), 32'(TMO));
    check("fault_req_low", 32'(dut_if.coin_req), 0);
    check("fault_coins_hold", 32'(dut_if.coins_left), 32'(model_coins(2)));
    check("fault_busy", 32'(dut_if.busy), 1);
    check("fault_req_pulses", 32'(req_rises - r0), 1);
    dut_if.redeem = 1'b1;
    repeat (5) tick();
    dut_if.redeem = 1'b0;
    tick();
    check("fault_sticky", 32'(dut_if.fault), 1);
    check("fault_no_reload", 32'(clr_cycles - c0), 1);
    check("fault_coins_frozen", 32'(dut_if.coins_left), 32'(model_coins(2)));
    check("fault_state", 32'(dbg_state), 32'(ST_FAULT));
    disp_en = 1'b1;
    do_reset("fault_rst");
  endtask

  task automatic run_mid_reset();
    int cnt;
    dut_if.bot_count = CNT_W'(3);
    exp_q.push_back(COIN_W'(model_coins(3)));
    dut_if.redeem = 1'b1;
    tick();
    dut_if.redeem = 1'b0;
    cnt = 0;
    while (!dut_if.coin_req && cnt < 5) begin
      tick();
      cnt++;
    end
    check("mid_rst_req_seen", 32'(dut_if.coin_req), 1);
    do_reset("mid_rst");
    run_payout(1, 1'b0);
  endtask

  initial begin
    dut_if.redeem    = 1'b0;
    dut_if.bot_count = '0;
    dut_if.coin_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    tick();
    req_prev   = dut_if.coin_req;
    coins_prev = dut_if.coins_left;

    run_payout(3, 1'b0);
    run_payout(0, 1'b0);
    run_payout(10, 1'b0);
    run_payout(8, 1'b1);
    run_fault();
    run_mid_reset();
    run_payout(128, 1'b0);
    run_payout(127, 1'b0);
    for (int i = 0; i < 8; i++) run_payout(int'($urandom_range(0, 20)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
